// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared state and mode encodings for mux_seq_scan
package mux_seq_pkg;
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN_CAP, SCAN_WAIT} state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/mux_seq_next_ch.sv
// mux_seq_next_ch: wrapping search for the next set mask bit from a start index
module mux_seq_next_ch
    import mux_seq_pkg::*;
#(
    parameter int NUM_CH = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              incl,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);
    logic [SEL_W-1:0] k;
    // scan offsets high to low so the nearest set bit is the one left standing
    always_comb begin
        nxt = '0;
        found = 1'b0;
        k = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            k = SEL_W'((int'(cur) + i - int'(incl)) % NUM_CH);
            if (mask[k]) begin
                nxt = k;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_seq_scan.sv
// mux_seq_scan: registered N-channel mux with direct select and masked timed scan
module mux_seq_scan
    import mux_seq_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         dout_ch,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     sel_err
);
    state_e state;
    logic [SEL_W-1:0] ptr, low_ch, after_ch;
    logic low_found, after_found;
    logic [DWELL_W-1:0] cnt;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] sel_data;
    logic sel_bad, stall, xfer;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_data[k] = din[k*DATA_W +: DATA_W];
    end

    assign sel_bad = int'(sel) >= NUM_CH;
    assign sel_data = sel_bad ? '0 : ch_data[sel];
    assign stall = dout_valid && !dout_ready;
    assign xfer = dout_valid && dout_ready;

    mux_seq_next_ch #(.NUM_CH(NUM_CH)) u_low (
        .mask(ch_mask), .cur('0), .incl(1'b1), .nxt(low_ch), .found(low_found)
    );
    mux_seq_next_ch #(.NUM_CH(NUM_CH)) u_after (
        .mask(ch_mask), .cur(ptr), .incl(1'b0), .nxt(after_ch), .found(after_found)
    );

    // control FSM, output sample register, scan pointer and dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            dout <= '0;
            dout_ch <= '0;
            dout_valid <= 1'b0;
            sel_err <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= mode == MODE_DIRECT ? DIRECT : SCAN_CAP;
                    if (mode == MODE_SCAN && low_found) ptr <= low_ch;
                end
                DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        state <= SCAN_CAP;
                        dout_valid <= 1'b0;
                        if (low_found) ptr <= low_ch;
                    end else if (!stall) begin
                        dout <= sel_data;
                        dout_ch <= sel;
                        dout_valid <= 1'b1;
                        sel_err <= sel_bad;
                    end
                end
                SCAN_CAP: begin
                    if (mode == MODE_DIRECT) begin
                        state <= DIRECT;
                        dout_valid <= 1'b0;
                    end else if (ch_mask[ptr]) begin
                        dout <= ch_data[ptr];
                        dout_ch <= ptr;
                        dout_valid <= 1'b1;
                        state <= SCAN_WAIT;
                    end else if (after_found) begin
                        ptr <= after_ch;
                    end
                end
                SCAN_WAIT: begin
                    if (mode == MODE_DIRECT) begin
                        state <= DIRECT;
                        dout_valid <= 1'b0;
                    end else begin
                        if (xfer) dout_valid <= 1'b0;
                        cnt <= xfer ? dwell : dout_valid ? cnt : cnt > DWELL_W'(1) ? cnt - DWELL_W'(1) : '0;
                        if (dout_valid ? xfer && dwell == '0 : cnt <= DWELL_W'(1)) begin
                            state <= SCAN_CAP;
                            if (after_found) ptr <= after_ch;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_seq_scan.sv
// tb_mux_seq_scan: randomized scoreboard bench for mux_seq_scan (8-ch and 6-ch instances)
module tb_mux_seq_scan;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, dout_ready = 1'b0;
    logic [2:0] sel8 = '0, sel6 = '0;
    logic [63:0] din8 = '0;
    logic [47:0] din6 = '0;
    logic [7:0] ch_mask = '0, dwell = '0, dwell6 = '0;
    logic [5:0] mask6 = '0;
    logic [7:0] dout8, dout6;
    logic [2:0] ch8, ch6;
    logic v8, v6, err8, err6;

    mux_seq_scan #(.NUM_CH(8), .DATA_W(8), .DWELL_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel8), .din(din8),
        .ch_mask(ch_mask), .dwell(dwell), .dout(dout8), .dout_ch(ch8),
        .dout_valid(v8), .dout_ready(dout_ready), .sel_err(err8)
    );
    mux_seq_scan #(.NUM_CH(6), .DATA_W(8), .DWELL_W(8)) u6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel6), .din(din6),
        .ch_mask(mask6), .dwell(dwell6), .dout(dout6), .dout_ch(ch6),
        .dout_valid(v6), .dout_ready(dout_ready), .sel_err(err6)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic [2:0] ch; logic err;} exp_t;
    exp_t q8[$], q6[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, last_xfer = 0, scan_dwell = 0;
    bit scan_chk = 0, have_xfer = 0, prev_v = 0, m_valid = 0, m_dir = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic extra(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output transferred with nothing expected (t=%0t)", nm, $time);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (scan_chk && v8 && !prev_v && have_xfer)
                    chk("scan_gap", cyc - last_xfer, scan_dwell + 2);
                if (v8 && dout_ready) begin
                    if (q8.size() == 0) extra("u8_xfer");
                    else begin
                        e = q8.pop_front();
                        chk("u8_xfer", {20'd0, dout8, ch8, err8}, {20'd0, e});
                    end
                    last_xfer = cyc;
                    have_xfer = 1;
                end
                if (v6 && dout_ready) begin
                    if (q6.size() == 0) extra("u6_xfer");
                    else begin
                        e = q6.pop_front();
                        chk("u6_xfer", {20'd0, dout6, ch6, err6}, {20'd0, e});
                    end
                end
            end
            prev_v = v8;
        end
    endtask

    task automatic step_direct(input logic e, input logic r, input logic [2:0] s8, input logic [2:0] s6);
        exp_t x;
        en = e;
        mode = 1'b0;
        dout_ready = r;
        sel8 = s8;
        sel6 = s6;
        if (!e) begin
            if (m_valid && !r) begin
                q8.delete(q8.size() - 1);
                q6.delete(q6.size() - 1);
            end
            m_valid = 0;
            m_dir = 0;
        end else if (!m_dir) begin
            m_dir = 1;
        end else if (!(m_valid && !r)) begin
            x.d = din8[int'(s8)*8 +: 8];
            x.ch = s8;
            x.err = 1'b0;
            q8.push_back(x);
            x.d = '0;
            if (s6 < 3'd6) x.d = din6[int'(s6)*8 +: 8];
            x.ch = s6;
            x.err = s6 >= 3'd6;
            q6.push_back(x);
            m_valid = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scan_phase(input logic [7:0] m, input logic [7:0] dw, input int n, input bit rnd);
        int chs[$];
        exp_t x;
        int c;
        ch_mask = m;
        dwell = dw;
        din8 = {$urandom(), $urandom()};
        scan_dwell = int'(dw);
        have_xfer = 0;
        scan_chk = 1;
        mode = 1'b1;
        for (int k = 0; k < 8; k++) if (m[k]) chs.push_back(k);
        for (int i = 0; i < n; i++) begin
            c = chs[i % chs.size()];
            x.d = din8[c*8 +: 8];
            x.ch = 3'(c);
            x.err = 1'b0;
            q8.push_back(x);
        end
        en = 1'b1;
        for (int t = 0; t < 600 && q8.size() > 0; t++) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        if (q8.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_timeout: %0d samples still owed for mask %h", q8.size(), m);
            q8.delete();
        end
        scan_chk = 0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_u8", {19'd0, dout8, ch8, v8, err8}, 32'd0);
        chk("reset_u6", {19'd0, dout6, ch6, v6, err6}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'h20 + k);
        repeat (2) step_direct(1'b0, 1'b1, 3'd0, 3'd0);
        repeat (3) step_direct(1'b1, 1'b1, 3'd5, 3'd7);
        step_direct(1'b1, 1'b1, 3'd5, 3'd2);
        for (int k = 0; k < 8; k++) step_direct(1'b1, 1'b1, 3'(k), 3'(k));
        for (int i = 0; i < 40; i++) begin
            din8 = {$urandom(), $urandom()};
            din6 = 48'({$urandom(), $urandom()});
            step_direct(1'b1, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        step_direct(1'b1, 1'b1, 3'd3, 3'd3);
        repeat (3) step_direct(1'b1, 1'b0, 3'd4, 3'd4);
        step_direct(1'b0, 1'b0, 3'd1, 3'd1);
        chk("disable_drops_valid", {30'd0, v8, v6}, 32'd0);
        step_direct(1'b0, 1'b1, 3'd0, 3'd0);
        chk("direct_drained", q8.size() + q6.size(), 0);

        scan_phase(8'b1010_0100, 8'd2, 8, 1'b0);
        scan_phase(8'b0000_1000, 8'd0, 6, 1'b0);
        repeat (4) scan_phase(8'($urandom_range(1, 255)), 8'($urandom_range(0, 5)), 8, 1'b1);

        ch_mask = '0;
        mode = 1'b1;
        en = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            cnt += int'(v8);
        end
        chk("empty_mask_no_valid", cnt, 0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        ch_mask = 8'h40;
        dwell = 8'd30;
        din8[55:48] = 8'hA5;
        q8.push_back({8'hA5, 3'd6, 1'b0});
        dout_ready = 1'b1;
        en = 1'b1;
        for (int t = 0; t < 50 && q8.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("reset_setup_drained", q8.size(), 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_u8", {19'd0, dout8, ch8, v8, err8}, 32'd0);
        chk("async_reset_u6", {30'd0, v6, err6}, 32'd0);
        en = 1'b0;
        q8.delete();
        q6.delete();
        m_valid = 0;
        m_dir = 0;
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_idle", {31'd0, v8}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
